// File: rtl/wishbone_arbiter.sv
// wishbone_arbiter: round-robin N-master Wishbone arbiter; optional stall timeout via WB_ARB_TIMEOUT_EN
module wishbone_arbiter #(
   parameter int N_MASTERS = 2,
   parameter int TIMEOUT   = 255
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [N_MASTERS-1:0]    m_cyc_i,
   input  logic [N_MASTERS-1:0]    m_stb_i,
   input  logic [N_MASTERS-1:0]    m_we_i,
   input  logic [32*N_MASTERS-1:0] m_adr_i,
   input  logic [32*N_MASTERS-1:0] m_dat_i,
   input  logic [4*N_MASTERS-1:0]  m_sel_i,
   output logic [31:0]             m_dat_o,
   output logic [N_MASTERS-1:0]    m_ack_o,
   output logic [N_MASTERS-1:0]    m_err_o,
   output logic [N_MASTERS-1:0]    m_rty_o,
   output logic                    s_cyc_o,
   output logic                    s_stb_o,
   output logic                    s_we_o,
   output logic [31:0]             s_adr_o,
   output logic [31:0]             s_dat_o,
   output logic [3:0]              s_sel_o,
   input  logic [31:0]             s_dat_i,
   input  logic                    s_ack_i,
   input  logic                    s_err_i,
   input  logic                    s_rty_i,
   output logic [N_MASTERS-1:0]    gnt_o
);
   localparam int PW = $clog2(N_MASTERS);
   typedef enum logic {IDLE, GRANT} state_t;
   state_t state_q, state_d;
   logic [N_MASTERS-1:0] gnt_q, gnt_d;
   logic [PW-1:0] ptr_q, ptr_d, idx_q, idx_d;
   logic found, act, to_err;
   int c;
   assign act = state_q == GRANT && !rst_i;
`ifdef WB_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] cnt_q, cnt_d;
   assign to_err = act && cnt_q == CW'(TIMEOUT);
   // stall counter: counts unterminated strobe cycles, cleared on any termination, timeout or idle
   always_comb begin
      cnt_d = (state_q != GRANT || to_err || s_ack_i || s_err_i || s_rty_i) ? '0 : s_stb_o ? cnt_q + 1'b1 : cnt_q;
   end
   // stall counter register
   always_ff @(posedge clk_i) begin
      cnt_q <= rst_i ? '0 : cnt_d;
   end
`else
   assign to_err = 1'b0;
`endif
   // next state: pick round-robin winner from ptr when idle, release on granted cyc drop
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      ptr_d   = ptr_q;
      idx_d   = idx_q;
      found   = 1'b0;
      c       = 0;
      if (state_q == IDLE) begin
         for (int i = 0; i < N_MASTERS; i++) begin
            c = int'(ptr_q) + i;
            c = c >= N_MASTERS ? c - N_MASTERS : c;
            if (!found && m_cyc_i[c]) begin
               found   = 1'b1;
               idx_d   = PW'(c);
               gnt_d   = N_MASTERS'(1) << c;
               state_d = GRANT;
            end
         end
      end else if (!m_cyc_i[idx_q]) begin
         state_d = IDLE;
         gnt_d   = '0;
         ptr_d   = idx_q == PW'(N_MASTERS - 1) ? '0 : idx_q + 1'b1;
      end
   end
   // state, grant and pointer registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         ptr_q   <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         ptr_q   <= ptr_d;
         idx_q   <= idx_d;
      end
   end
   // combinational request mux to the slave and termination routing back to the winner
   always_comb begin
      s_cyc_o = act && m_cyc_i[idx_q];
      s_stb_o = act && !to_err && m_stb_i[idx_q];
      s_we_o  = act && m_we_i[idx_q];
      s_adr_o = act ? m_adr_i[32*idx_q +: 32] : '0;
      s_dat_o = act ? m_dat_i[32*idx_q +: 32] : '0;
      s_sel_o = act ? m_sel_i[4*idx_q +: 4] : '0;
      m_ack_o = act ? gnt_q & {N_MASTERS{s_ack_i}} : '0;
      m_err_o = act ? gnt_q & {N_MASTERS{s_err_i || to_err}} : '0;
      m_rty_o = act ? gnt_q & {N_MASTERS{s_rty_i}} : '0;
   end
   assign m_dat_o = s_dat_i;
   assign gnt_o   = gnt_q;
endmodule
